// File: rtl/trans_addr_gen_pkg.sv
// Shared definitions for the transpose-write address generator.
// State encoding and default widths shared with the downstream register stage.
package trans_addr_gen_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DIM_W_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/trans_addr_gen.sv
// Paired row-major / column-major write address generator for one tile.
// Advances one element per accepted upstream beat; addresses by accumulation.
module trans_addr_gen
    import trans_addr_gen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [ADDR_W-1:0] cfg_base1,
    input  logic [ADDR_W-1:0] cfg_base2,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] TRANS_ADDR1,
    output logic [ADDR_W-1:0] TRANS_ADDR2,
    output logic              WRITE,
    output logic              busy,
    output logic              done
);

    state_t              state_q;
    logic [DIM_W-1:0]    rows_q;
    logic [DIM_W-1:0]    cols_q;
    logic [DIM_W-1:0]    row_q;
    logic [DIM_W-1:0]    col_q;
    logic [ADDR_W-1:0]   a1_q;
    logic [ADDR_W-1:0]   a2_q;
    logic [ADDR_W-1:0]   cs_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [ADDR_W-1:0]   addr2_q;
    logic                write_q;
    logic                busy_q;
    logic                done_q;

    logic                last_col;
    logic                last_row;

    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));

    // Tile sequencer: counters, address accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            cs_q    <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A start overlapping the done pulse is dropped.
                    if (start && !done_q) begin
                        rows_q <= cfg_rows;
                        cols_q <= cfg_cols;
                        row_q  <= '0;
                        col_q  <= '0;
                        a1_q   <= cfg_base1;
                        a2_q   <= cfg_base2;
                        cs_q   <= cfg_base2;
                        busy_q <= 1'b1;
                        if (cfg_rows == '0 || cfg_cols == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        write_q <= 1'b1;
                        addr1_q <= a1_q;
                        addr2_q <= a2_q;
                        a1_q    <= a1_q + ADDR_W'(1);
                        if (!last_col) begin
                            col_q <= col_q + DIM_W'(1);
                            a2_q  <= a2_q + ADDR_W'(rows_q);
                        end else begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                            cs_q  <= cs_q + ADDR_W'(1);
                            a2_q  <= cs_q + ADDR_W'(1);
                        end
                        if (last_row && last_col) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TRANS_ADDR1 = addr1_q;
    assign TRANS_ADDR2 = addr2_q;
    assign WRITE       = write_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_trans_addr_gen.sv
// Self-checking bench for trans_addr_gen.
// Closed-form element model compared every cycle, plus literal sequence checks.
module tb_trans_addr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] cfg_rows = '0;
    logic [5:0] cfg_cols = '0;
    logic [9:0] cfg_base1 = '0;
    logic [9:0] cfg_base2 = '0;
    logic       in_valid = 1'b0;
    logic [9:0] TRANS_ADDR1;
    logic [9:0] TRANS_ADDR2;
    logic       WRITE;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    trans_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_base1  (cfg_base1),
        .cfg_base2  (cfg_base2),
        .in_valid   (in_valid),
        .TRANS_ADDR1(TRANS_ADDR1),
        .TRANS_ADDR2(TRANS_ADDR2),
        .WRITE      (WRITE),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Element-level model: phase 0 idle, 1 running, 2 finishing.
    int m_ph = 0;
    int m_idx = 0;
    int m_r = 0;
    int m_c = 0;
    int m_b1 = 0;
    int m_b2 = 0;
    logic       e_w = 1'b0;
    logic       e_done = 1'b0;
    logic [9:0] e_a1 = '0;
    logic [9:0] e_a2 = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_ph   <= 0;
            m_idx  <= 0;
            e_w    <= 1'b0;
            e_done <= 1'b0;
            e_a1   <= '0;
            e_a2   <= '0;
        end else begin
            e_w    <= 1'b0;
            e_done <= 1'b0;
            if (m_ph == 0) begin
                if (start && !e_done) begin
                    m_r   <= int'(cfg_rows);
                    m_c   <= int'(cfg_cols);
                    m_b1  <= int'(cfg_base1);
                    m_b2  <= int'(cfg_base2);
                    m_idx <= 0;
                    m_ph  <= (cfg_rows == 0 || cfg_cols == 0) ? 2 : 1;
                end
            end else if (m_ph == 1) begin
                if (in_valid) begin
                    e_w   <= 1'b1;
                    e_a1  <= 10'(m_b1 + m_idx);
                    e_a2  <= 10'(m_b2 + (m_idx % m_c) * m_r + m_idx / m_c);
                    m_idx <= m_idx + 1;
                    if (m_idx + 1 == m_r * m_c) m_ph <= 2;
                end
            end else begin
                e_done <= 1'b1;
                m_ph   <= 0;
            end
        end
    end

    // Capture log for literal checks.
    int cyc = 0;
    int nw = 0;
    int ndone = 0;
    int first_w = 0;
    int last_w = 0;
    int done_cyc = 0;
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        chk("write", int'(WRITE), int'(e_w));
        chk("done", int'(done), int'(e_done));
        chk("busy", int'(busy), int'(m_ph != 0));
        chk("addr1", int'(TRANS_ADDR1), int'(e_a1));
        chk("addr2", int'(TRANS_ADDR2), int'(e_a2));
        if (WRITE) begin
            q1.push_back(TRANS_ADDR1);
            q2.push_back(TRANS_ADDR2);
            nw++;
            if (nw == 1) first_w = cyc;
            last_w = cyc;
        end
        if (done) begin
            ndone++;
            if (ndone == 1) done_cyc = cyc;
        end
    end

    int sc = 0;

    task automatic clr();
        q1.delete();
        q2.delete();
        nw = 0;
        ndone = 0;
        first_w = 0;
        last_w = 0;
        done_cyc = 0;
    endtask

    task automatic run_tile(input int r, input int c, input int b1,
                            input int b2, input logic [15:0] pat,
                            input int npat, input bit mid);
        clr();
        @(negedge clk);
        cfg_rows  = 6'(r);
        cfg_cols  = 6'(c);
        cfg_base1 = 10'(b1);
        cfg_base2 = 10'(b2);
        start     = 1'b1;
        @(posedge clk);
        #2 sc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < npat; i++) begin
            in_valid = pat[i];
            if (mid && i == 1) begin
                start     = 1'b1;
                cfg_rows  = 6'd7;
                cfg_base1 = 10'd55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < 40 && ndone == 0; i++) @(negedge clk);
        chk("done_seen", int'(ndone > 0), 1);
        @(negedge clk);
    endtask

    int ex1[6] = '{0, 1, 2, 3, 4, 5};
    int ex2[6] = '{100, 102, 104, 101, 103, 105};
    int wr1[4] = '{1022, 1023, 0, 1};

    initial begin
        rst = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_write", int'(WRITE), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_a1", int'(TRANS_ADDR1), 0);
        chk("rst_a2", int'(TRANS_ADDR2), 0);
        start = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_tile(2, 3, 0, 100, 16'hffff, 6, 1'b0);
        chk("c_nw", nw, 6);
        for (int i = 0; i < 6; i++) begin
            chk("c_a1", int'(q1[i]), ex1[i]);
            chk("c_a2", int'(q2[i]), ex2[i]);
        end
        chk("c_span", last_w - first_w, 5);
        chk("c_done_lat", done_cyc - last_w, 1);
        chk("c_ndone", ndone, 1);
        chk("c_busy_end", int'(busy), 0);

        run_tile(2, 3, 0, 100, 16'b111011001, 9, 1'b0);
        chk("p_nw", nw, 6);
        for (int i = 0; i < 6; i++) begin
            chk("p_a1", int'(q1[i]), ex1[i]);
            chk("p_a2", int'(q2[i]), ex2[i]);
        end
        chk("p_first", first_w - sc, 1);
        chk("p_span", last_w - first_w, 8);
        chk("p_done_lat", done_cyc - last_w, 1);

        run_tile(0, 5, 7, 9, 16'h0, 0, 1'b0);
        chk("z_nw", nw, 0);
        chk("z_done_lat", done_cyc - sc, 1);
        chk("z_ndone", ndone, 1);
        chk("z_busy", int'(busy), 0);

        run_tile(1, 4, 1022, 10, 16'hffff, 4, 1'b1);
        chk("w_nw", nw, 4);
        for (int i = 0; i < 4; i++) begin
            chk("w_a1", int'(q1[i]), wr1[i]);
            chk("w_a2", int'(q2[i]), 10 + i);
        end

        clr();
        @(negedge clk);
        cfg_rows  = 6'd4;
        cfg_cols  = 6'd4;
        cfg_base1 = 10'd200;
        cfg_base2 = 10'd300;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && nw < 3; i++) @(negedge clk);
        chk("r_nw3", nw, 3);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("r_write", int'(WRITE), 0);
        chk("r_a1", int'(TRANS_ADDR1), 0);
        chk("r_a2", int'(TRANS_ADDR2), 0);
        chk("r_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("r_nodone", ndone, 0);

        run_tile(4, 4, 200, 300, 16'hffff, 16, 1'b0);
        chk("f_nw", nw, 16);
        chk("f_a1_last", int'(q1[15]), 215);
        chk("f_a2_1", int'(q2[1]), 304);
        chk("f_a2_4", int'(q2[4]), 301);
        chk("f_a2_last", int'(q2[15]), 315);
        chk("f_ndone", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
